// File: rtl/id_ser_pkg.sv
// Shared types and helpers for the binary-to-decimal ID digit serializer.
package id_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SKIP = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Width needed to hold values 0..v-1; never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/id_digit_serializer_if.sv
// Value-in / digit-out handshake bundle for id_digit_serializer.
interface id_ser_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/id_bcd_step.sv
// One double-dabble iteration: add 3 to each nibble >= 5, then shift left taking bit_i as the new LSB.
module id_bcd_step
  import id_ser_pkg::*;
#(
  parameter int unsigned DIGITS = 10
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic                bit_i,
  output logic [4*DIGITS-1:0] bcd_o
);

  function automatic logic [3:0] fix4(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [2:0] fix3(input logic [3:0] n);
    return (n >= 4'd5) ? 3'(n + 4'd3) : n[2:0];
  endfunction

  assign bcd_o[0] = bit_i;

  // The top nibble's MSB shifts out; the DIGITS sizing guarantees it is always zero.
  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    if (g == DIGITS - 1) begin : g_top
      assign bcd_o[4*g+1 +: 3] = fix3(bcd_i[4*g +: 4]);
    end else begin : g_mid
      assign bcd_o[4*g+1 +: 4] = fix4(bcd_i[4*g +: 4]);
    end
  end

endmodule

// File: rtl/id_digit_serializer.sv
// Converts a WIDTH-bit value to BCD and streams the digits MSD first.
// ID_SER_ASCII_EN selects ASCII digit codes; otherwise raw BCD in the low nibble.
module id_digit_serializer
  import id_ser_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DIGITS      = 10,
  parameter bit          SUPPRESS_LZ = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  id_ser_if.slave  bus,
  output logic     busy
);

  localparam int unsigned CNT_W = clog2_min1(WIDTH + 1);
  localparam int unsigned IDX_W = clog2_min1(DIGITS);
  localparam int unsigned BCD_W = 4 * DIGITS;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         nib;

  id_bcd_step #(.DIGITS(DIGITS)) u_step (
    .bcd_i (bcd_q),
    .bit_i (shreg_q[WIDTH-1]),
    .bcd_o (bcd_step)
  );

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    nib           = bcd_q[{idx_q, 2'b00} +: 4];
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = bcd_step;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          idx_d   = IDX_W'(DIGITS - 1);
          state_d = SUPPRESS_LZ ? SKIP : SEND;
        end
      end
      SKIP: begin
        // Index 0 is never skipped so a zero value still yields one digit.
        if (nib == 4'd0 && idx_q != '0) idx_d = idx_q - 1'b1;
        else                            state_d = SEND;
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (idx_q == '0);
`ifdef ID_SER_ASCII_EN
        bus.out_data  = ASCII_ZERO | {4'b0000, nib};
`else
        bus.out_data  = {4'b0000, nib};
`endif
        if (bus.out_ready) begin
          if (idx_q == '0) state_d = IDLE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_id_digit_serializer.sv
// Directed bench for id_digit_serializer: one instance streams all digits, one strips leading zeros.
module tb_id_digit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy0, busy1;
  int   checks   = 0;
  int   failures = 0;
  byte unsigned exp_q[$];
  int   lat;

  always #5 clk = ~clk;

  id_ser_if #(.WIDTH(32)) bus0 ();
  id_ser_if #(.WIDTH(32)) bus1 ();

  id_digit_serializer #(.WIDTH(32), .DIGITS(10), .SUPPRESS_LZ(1'b0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0), .busy (busy0)
  );

  id_digit_serializer #(.WIDTH(32), .DIGITS(10), .SUPPRESS_LZ(1'b1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1), .busy (busy1)
  );

  function automatic logic [7:0] enc(input byte unsigned d);
`ifdef ID_SER_ASCII_EN
    return 8'h30 | {4'h0, d[3:0]};
`else
    return {4'h0, d[3:0]};
`endif
  endfunction

  function automatic logic ov(input int s);
    return (s == 0) ? bus0.out_valid : bus1.out_valid;
  endfunction
  function automatic logic [7:0] od(input int s);
    return (s == 0) ? bus0.out_data : bus1.out_data;
  endfunction
  function automatic logic ol(input int s);
    return (s == 0) ? bus0.out_last : bus1.out_last;
  endfunction
  function automatic logic ir(input int s);
    return (s == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction
  function automatic logic bz(input int s);
    return (s == 0) ? busy0 : busy1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic [31:0] v, input bit strip);
    byte unsigned d[10];
    int first;
    logic [31:0] t;
    t = v;
    for (int i = 0; i < 10; i++) begin
      d[i] = 8'(t % 10);
      t = t / 10;
    end
    first = 9;
    if (strip) while (first > 0 && d[first] == 0) first--;
    exp_q.delete();
    for (int i = first; i >= 0; i--) exp_q.push_back(d[i]);
  endtask

  task automatic check_idle(input int s, input string tag);
    check({tag, "_out_valid"}, 32'(ov(s)), 32'd0);
    check({tag, "_out_last"},  32'(ol(s)), 32'd0);
    check({tag, "_out_data"},  32'(od(s)), 32'd0);
    check({tag, "_in_ready"},  32'(ir(s)), 32'd1);
    check({tag, "_busy"},      32'(bz(s)), 32'd0);
  endtask

  // Called at a negedge; returns the number of negedges from acceptance to first out_valid.
  task automatic push(input int s, input logic [31:0] v, input bit hold,
                      input logic [31:0] next_v, output int l);
    bit ok;
    ok = 1'b0;
    l  = -1;
    if (s == 0) begin bus0.in_valid = 1'b1; bus0.in_data = v; end
    else        begin bus1.in_valid = 1'b1; bus1.in_data = v; end
    for (int i = 0; i < 200; i++) begin
      if (ir(s)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus0.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
      return;
    end
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (hold) begin
          if (s == 0) bus0.in_data = next_v; else bus1.in_data = next_v;
        end else begin
          if (s == 0) bus0.in_valid = 1'b0; else bus1.in_valid = 1'b0;
        end
      end
      if (ov(s)) begin l = i; break; end
    end
    if (l < 0) check("first_valid_timeout", 32'd0, 32'd1);
  endtask

  // Consumes digits against exp_q; stop_after>0 leaves the stream mid-value.
  task automatic collect(input int s, input int stop_after, input bit rnd, input string tag);
    int beat, n, stop;
    bit pv, pr, done;
    logic [7:0] pd;
    logic pl;
    beat = 0; pv = 0; pr = 0; done = 0; pd = '0; pl = 1'b0;
    n    = exp_q.size();
    stop = (stop_after > 0) ? stop_after : n;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      logic v, r;
      v = ov(s);
      if (pv && !pr) begin
        check({tag, "_hold_valid"}, 32'(v), 32'd1);
        check({tag, "_hold_data"},  32'(od(s)), 32'(pd));
        check({tag, "_hold_last"},  32'(ol(s)), 32'(pl));
      end
      if (v) check({tag, "_in_ready_low"}, 32'(ir(s)), 32'd0);
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus0.out_ready = r;
      bus1.out_ready = r;
      if (v && r) begin
        check({tag, "_digit"}, 32'(od(s)), 32'(enc(exp_q[beat])));
        check({tag, "_last"},  32'(ol(s)), 32'(beat == n - 1));
        beat++;
        if (beat == stop) done = 1'b1;
      end
      pv = v; pr = r; pd = od(s); pl = ol(s);
      @(negedge clk);
    end
    if (!done) check({tag, "_beat_timeout"}, 32'(beat), 32'(stop));
    if (stop == n) begin
      check({tag, "_end_valid"},    32'(ov(s)), 32'd0);
      check({tag, "_end_busy"},     32'(bz(s)), 32'd0);
      check({tag, "_end_in_ready"}, 32'(ir(s)), 32'd1);
    end
  endtask

  initial begin
    int seen;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst = 1'b0;
    @(negedge clk);
    check_idle(0, "post_reset0");

    exp_q = '{2, 0, 1, 5, 0, 3, 6, 5, 8, 0};
    push(0, 32'd2015036580, 1'b0, '0, lat);
    check("t1_latency", 32'(lat), 32'd33);
    collect(0, 0, 1'b0, "t1");

    exp_q = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 5};
    push(0, 32'hFFFF_FFFF, 1'b0, '0, lat);
    check("t2_latency", 32'(lat), 32'd33);
    collect(0, 0, 1'b0, "t2");

    exp_q = '{0};
    push(1, 32'd0, 1'b0, '0, lat);
    collect(1, 0, 1'b0, "lz_zero");

    exp_q = '{1, 0, 5, 0};
    push(1, 32'd1050, 1'b0, '0, lat);
    collect(1, 0, 1'b0, "lz_1050");

    set_dec(32'd4000000009, 1'b1);
    push(1, 32'd4000000009, 1'b0, '0, lat);
    collect(1, 0, 1'b0, "lz_full");

    exp_q = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    push(0, 32'd3141592653, 1'b0, '0, lat);
    collect(0, 0, 1'b1, "bp");

    set_dec(32'd7, 1'b0);
    push(0, 32'd7, 1'b1, 32'd42, lat);
    check("hold7_latency", 32'(lat), 32'd33);
    collect(0, 0, 1'b0, "hold7");
    set_dec(32'd42, 1'b0);
    push(0, 32'd42, 1'b0, '0, lat);
    check("hold42_latency", 32'(lat), 32'd33);
    collect(0, 0, 1'b0, "hold42");

    bus0.in_valid = 1'b1; bus0.in_data = 32'd5000;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("conv_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle(0, "rst_conv");
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ov(0)) seen++;
    end
    check("rst_conv_no_resume", 32'(seen), 32'd0);

    set_dec(32'd987654321, 1'b0);
    push(0, 32'd987654321, 1'b0, '0, lat);
    collect(0, 4, 1'b0, "rst_send");
    check("rst_send_midstream", 32'(ov(0)), 32'd1);
    rst = 1'b1;
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    check_idle(0, "rst_send");
    rst = 1'b0;
    @(negedge clk);

    set_dec(32'd123, 1'b0);
    push(0, 32'd123, 1'b0, '0, lat);
    check("after_rst_latency", 32'(lat), 32'd33);
    collect(0, 0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
